// File: rtl/drive_mode_ctrl.sv
// Registered power/run/moving-state controller arbitrating manual logic and an auto-pilot source.
// Define IDLE_OFF_EN to enable automatic power-off after IDLE_CYC cycles idling in NSTART.
module drive_mode_ctrl #(
  parameter int unsigned PWR_HOLD_CYC = 100_000_000,
  parameter int unsigned TURN_CYC     = 90_000_000
`ifdef IDLE_OFF_EN
  , parameter int unsigned IDLE_CYC   = 500_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_btn,
  input  logic [1:0] mode_sel,
  input  logic [1:0] man_next_state,
  input  logic [3:0] man_next_moving,
  input  logic       man_power,
  input  logic       auto_valid,
  input  logic [3:0] auto_cmd,
  output logic       auto_ready,
  output logic       power,
  output logic [1:0] state,
  output logic [3:0] moving_state,
  output logic       active_mode
);
  localparam int unsigned HOLD_W = $clog2(PWR_HOLD_CYC + 1);
  localparam int unsigned TURN_W = $clog2(TURN_CYC + 1);
`ifdef IDLE_OFF_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);
`endif

  localparam logic [1:0] S_NSTART = 2'b00;
  localparam logic [1:0] S_START  = 2'b01;
  localparam logic [1:0] S_MOVING = 2'b10;
  localparam logic [3:0] M_NONE   = 4'b0000;
  localparam logic [3:0] M_FWD    = 4'b0001;
  localparam logic [3:0] M_LEFT   = 4'b0010;
  localparam logic [3:0] M_RIGHT  = 4'b0100;

  typedef enum logic [1:0] {P_OFF, P_WAIT_REL, P_ON, P_WAIT_REL_OFF} pwr_state_e;

  pwr_state_e        r_pst, w_pst_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [TURN_W-1:0] r_turn_cnt, w_turn_nxt;
  logic              r_power, w_power_nxt;
  logic [1:0]        r_state, w_state_nxt;
  logic [3:0]        r_moving, w_moving_nxt;
  logic              r_active, w_active_nxt;
  logic              r_turning, w_turning_nxt;
  logic              r_ready, w_ready_nxt;
  logic              w_off;
  logic              w_cmd_acc;
`ifdef IDLE_OFF_EN
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
`endif

  assign w_cmd_acc = auto_valid & r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pst      <= P_OFF;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_power    <= 1'b0;
      r_state    <= S_NSTART;
      r_moving   <= M_NONE;
      r_active   <= 1'b0;
      r_turning  <= 1'b0;
      r_ready    <= 1'b0;
`ifdef IDLE_OFF_EN
      r_idle_cnt <= '0;
`endif
    end else begin
      r_pst      <= w_pst_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_power    <= w_power_nxt;
      r_state    <= w_state_nxt;
      r_moving   <= w_moving_nxt;
      r_active   <= w_active_nxt;
      r_turning  <= w_turning_nxt;
      r_ready    <= w_ready_nxt;
`ifdef IDLE_OFF_EN
      r_idle_cnt <= w_idle_nxt;
`endif
    end
  end

  always_comb begin
    w_pst_nxt     = r_pst;
    w_hold_nxt    = r_hold_cnt;
    w_turn_nxt    = r_turn_cnt;
    w_power_nxt   = r_power;
    w_state_nxt   = r_state;
    w_moving_nxt  = r_moving;
    w_active_nxt  = r_active;
    w_turning_nxt = r_turning;
    w_off         = 1'b0;
`ifdef IDLE_OFF_EN
    w_idle_nxt    = '0;
`endif
    // Hold-to-toggle; the WAIT states demand a release before the next hold counts
    case (r_pst)
      P_OFF, P_ON: begin
        if (!power_btn) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt == HOLD_W'(PWR_HOLD_CYC - 1)) begin
          w_hold_nxt = '0;
          if (r_pst == P_OFF) begin
            w_pst_nxt   = P_WAIT_REL;
            w_power_nxt = 1'b1;
          end else begin
            w_pst_nxt = P_WAIT_REL_OFF;
            w_off     = 1'b1;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      P_WAIT_REL:     if (!power_btn) w_pst_nxt = P_ON;
      P_WAIT_REL_OFF: if (!power_btn) w_pst_nxt = P_OFF;
      default:        w_pst_nxt = P_OFF;
    endcase

    // Manual logic stalling the engine
    if (r_power && !r_active && !man_power && !w_off) begin
      w_off      = 1'b1;
      w_pst_nxt  = P_OFF;
      w_hold_nxt = '0;
    end

`ifdef IDLE_OFF_EN
    if (r_pst == P_ON && r_state == S_NSTART) begin
      if (r_idle_cnt != IDLE_W'(IDLE_CYC - 1)) begin
        w_idle_nxt = r_idle_cnt + IDLE_W'(1);
      end else if (!w_off) begin
        w_off      = 1'b1;
        w_pst_nxt  = P_OFF;
        w_hold_nxt = '0;
      end
    end
`endif

    if (w_off) w_power_nxt = 1'b0;

    if (w_off || !r_power) begin
      w_state_nxt   = S_NSTART;
      w_moving_nxt  = M_NONE;
      w_active_nxt  = 1'b0;
      w_turning_nxt = 1'b0;
      w_turn_nxt    = '0;
    end else if (!r_active) begin
      w_state_nxt  = man_next_state;
      w_moving_nxt = man_next_moving;
      if (r_state != S_MOVING && mode_sel == 2'b01) begin
        w_active_nxt = 1'b1;
        w_state_nxt  = S_START;
        w_moving_nxt = M_NONE;
      end
    end else begin
      // Auto: brake beats a command, a command beats turn expiry
      if (man_next_state == S_NSTART) begin
        w_state_nxt   = S_NSTART;
        w_moving_nxt  = M_NONE;
        w_turning_nxt = 1'b0;
        w_turn_nxt    = '0;
      end else if (w_cmd_acc) begin
        case (auto_cmd)
          M_FWD: begin
            w_state_nxt  = S_MOVING;
            w_moving_nxt = M_FWD;
          end
          M_LEFT, M_RIGHT: begin
            w_state_nxt   = S_MOVING;
            w_moving_nxt  = auto_cmd;
            w_turning_nxt = 1'b1;
            w_turn_nxt    = TURN_W'(TURN_CYC - 1);
          end
          M_NONE: begin
            w_state_nxt  = S_START;
            w_moving_nxt = M_NONE;
          end
          default: ;
        endcase
      end else if (r_turning) begin
        if (r_turn_cnt == '0) begin
          w_turning_nxt = 1'b0;
          w_moving_nxt  = M_FWD;
        end else begin
          w_turn_nxt = r_turn_cnt - TURN_W'(1);
        end
      end
      if (r_state != S_MOVING && mode_sel != 2'b01) begin
        w_active_nxt  = 1'b0;
        w_turning_nxt = 1'b0;
        w_turn_nxt    = '0;
      end
    end

    w_ready_nxt = w_power_nxt & w_active_nxt & ~w_turning_nxt;
  end

  assign auto_ready   = r_ready;
  assign power        = r_power;
  assign state        = r_state;
  assign moving_state = r_moving;
  assign active_mode  = r_active;
endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Bench for drive_mode_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_drive_mode_ctrl;
  localparam int unsigned PWR_HOLD = 8;
  localparam int unsigned TURN     = 4;
  localparam int unsigned IDLE     = 10;

  logic       clk;
  logic       rst;
  logic       power_btn;
  logic [1:0] mode_sel;
  logic [1:0] man_next_state;
  logic [3:0] man_next_moving;
  logic       man_power;
  logic       auto_valid;
  logic [3:0] auto_cmd;
  logic       auto_ready;
  logic       power;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic       active_mode;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: hold lengths and remaining turn cycles kept as plain counts
  logic        m_power, m_active, m_ready, m_lock;
  logic [1:0]  m_state;
  logic [3:0]  m_moving;
  int unsigned m_hold, m_turn, m_idle;

  drive_mode_ctrl #(
    .PWR_HOLD_CYC(PWR_HOLD),
    .TURN_CYC(TURN)
`ifdef IDLE_OFF_EN
    , .IDLE_CYC(IDLE)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .power_btn(power_btn),
    .mode_sel(mode_sel),
    .man_next_state(man_next_state),
    .man_next_moving(man_next_moving),
    .man_power(man_power),
    .auto_valid(auto_valid),
    .auto_cmd(auto_cmd),
    .auto_ready(auto_ready),
    .power(power),
    .state(state),
    .moving_state(moving_state),
    .active_mode(active_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    bit          off, on;
    logic        n_lock, n_active, n_power;
    logic [1:0]  n_state;
    logic [3:0]  n_moving;
    int unsigned n_hold, n_turn, n_idle;
    if (rst) begin
      m_power = 0; m_active = 0; m_ready = 0; m_lock = 0;
      m_state = 2'b00; m_moving = 4'b0000;
      m_hold = 0; m_turn = 0; m_idle = 0;
      return;
    end
    off = 0; on = 0;
    n_lock = m_lock; n_hold = m_hold; n_idle = 0;
    n_state = m_state; n_moving = m_moving; n_active = m_active; n_turn = m_turn;
    if (m_lock) begin
      if (!power_btn) n_lock = 0;
    end else if (power_btn) begin
      n_hold = m_hold + 1;
      if (n_hold == PWR_HOLD) begin
        n_hold = 0; n_lock = 1;
        if (m_power) off = 1; else on = 1;
      end
    end else begin
      n_hold = 0;
    end
    if (m_power && !m_active && !man_power && !off) begin
      off = 1; n_lock = 0; n_hold = 0;
    end
`ifdef IDLE_OFF_EN
    if (m_power && !m_lock && m_state == 2'b00) begin
      n_idle = m_idle + 1;
      if (n_idle == IDLE) begin
        n_idle = 0;
        if (!off) begin off = 1; n_lock = 0; n_hold = 0; end
      end
    end
`endif
    if (off || !m_power) begin
      n_state = 2'b00; n_moving = 4'b0000; n_active = 0; n_turn = 0;
    end else if (!m_active) begin
      n_state = man_next_state; n_moving = man_next_moving;
      if (m_state != 2'b10 && mode_sel == 2'b01) begin
        n_active = 1; n_state = 2'b01; n_moving = 4'b0000;
      end
    end else begin
      if (man_next_state == 2'b00) begin
        n_state = 2'b00; n_moving = 4'b0000; n_turn = 0;
      end else if (auto_valid && m_ready) begin
        if (auto_cmd == 4'b0001) begin
          n_state = 2'b10; n_moving = 4'b0001;
        end else if (auto_cmd == 4'b0010 || auto_cmd == 4'b0100) begin
          n_state = 2'b10; n_moving = auto_cmd; n_turn = TURN;
        end else if (auto_cmd == 4'b0000) begin
          n_state = 2'b01; n_moving = 4'b0000;
        end
      end else if (m_turn > 0) begin
        if (m_turn == 1) n_moving = 4'b0001;
        n_turn = m_turn - 1;
      end
      if (m_state != 2'b10 && mode_sel != 2'b01) begin
        n_active = 0; n_turn = 0;
      end
    end
    n_power = off ? 1'b0 : (on ? 1'b1 : m_power);
    m_power = n_power; m_lock = n_lock; m_hold = n_hold; m_idle = n_idle;
    m_state = n_state; m_moving = n_moving; m_active = n_active; m_turn = n_turn;
    m_ready = n_power && n_active && (n_turn == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic power_on();
    power_btn = 1'b1;
    repeat (PWR_HOLD) tick();
    power_btn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (power !== 1'b0) begin n_fail++; $display("FAIL reset_power got=%b exp=0", power); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got=%b exp=00", state); end
    n_checks++; if (moving_state !== 4'b0000) begin n_fail++; $display("FAIL reset_moving got=%b exp=0000", moving_state); end
    n_checks++; if (auto_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", auto_ready); end
    n_checks++; if (active_mode !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", active_mode); end
    rst = 1'b0;
  endtask

  task automatic test_power_toggle();
    power_btn = 1'b1; repeat (PWR_HOLD - 1) tick();
    power_btn = 1'b0; tick();
    n_checks++; if (power !== 1'b0) begin n_fail++; $display("FAIL short_hold got=%b exp=0", power); end
    power_btn = 1'b1; repeat (PWR_HOLD - 1) tick();
    n_checks++; if (power !== 1'b0) begin n_fail++; $display("FAIL hold_minus1 got=%b exp=0", power); end
    tick();
    n_checks++; if (power !== 1'b1) begin n_fail++; $display("FAIL hold_on got=%b exp=1", power); end
    repeat (2 * PWR_HOLD) tick();
    n_checks++; if (power !== 1'b1) begin n_fail++; $display("FAIL stuck_no_retoggle got=%b exp=1", power); end
    power_btn = 1'b0; tick();
    power_btn = 1'b1; repeat (PWR_HOLD - 1) tick();
    n_checks++; if (power !== 1'b1) begin n_fail++; $display("FAIL off_hold_minus1 got=%b exp=1", power); end
    tick();
    n_checks++; if (power !== 1'b0) begin n_fail++; $display("FAIL hold_off got=%b exp=0", power); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL hold_off_state got=%b exp=00", state); end
    power_btn = 1'b0; tick();
  endtask

  task automatic test_manual();
    power_on();
    man_next_state = 2'b10; man_next_moving = 4'b0100; tick();
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL man_state got=%b exp=10", state); end
    n_checks++; if (moving_state !== 4'b0100) begin n_fail++; $display("FAIL man_moving got=%b exp=0100", moving_state); end
    man_power = 1'b0; tick();
    n_checks++; if (power !== 1'b0) begin n_fail++; $display("FAIL stall_power got=%b exp=0", power); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL stall_state got=%b exp=00", state); end
    n_checks++; if (moving_state !== 4'b0000) begin n_fail++; $display("FAIL stall_moving got=%b exp=0000", moving_state); end
    man_power = 1'b1; man_next_state = 2'b00; man_next_moving = 4'b0000; tick();
  endtask

  task automatic test_mode_switch();
    power_on();
    man_next_state = 2'b10; man_next_moving = 4'b0001; tick();
    mode_sel = 2'b01; tick();
    n_checks++; if (active_mode !== 1'b0) begin n_fail++; $display("FAIL switch_held got=%b exp=0", active_mode); end
    man_next_state = 2'b01; man_next_moving = 4'b0000; tick();
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL leave_moving got=%b exp=01", state); end
    tick();
    n_checks++; if (active_mode !== 1'b1) begin n_fail++; $display("FAIL switch_auto got=%b exp=1", active_mode); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL auto_entry_state got=%b exp=01", state); end
    n_checks++; if (auto_ready !== 1'b1) begin n_fail++; $display("FAIL auto_entry_ready got=%b exp=1", auto_ready); end
  endtask

  task automatic test_auto_turn();
    auto_valid = 1'b1; auto_cmd = 4'b0001; tick();
    n_checks++; if (state !== 2'b10 || moving_state !== 4'b0001) begin n_fail++; $display("FAIL fwd got=%b/%b exp=10/0001", state, moving_state); end
    auto_cmd = 4'b0100; tick();
    auto_valid = 1'b0;
    for (int k = 0; k < int'(TURN); k++) begin
      if (k > 0) tick();
      n_checks++; if (moving_state !== 4'b0100 || auto_ready !== 1'b0) begin n_fail++; $display("FAIL turn_hold k=%0d got=%b/%b exp=0100/0", k, moving_state, auto_ready); end
    end
    tick();
    n_checks++; if (moving_state !== 4'b0001 || auto_ready !== 1'b1) begin n_fail++; $display("FAIL turn_expire got=%b/%b exp=0001/1", moving_state, auto_ready); end
    auto_valid = 1'b1; auto_cmd = 4'b0010; tick();
    auto_valid = 1'b0; tick();
    man_next_state = 2'b00; tick();
    n_checks++; if (state !== 2'b00 || moving_state !== 4'b0000) begin n_fail++; $display("FAIL brake_turn got=%b/%b exp=00/0000", state, moving_state); end
    n_checks++; if (auto_ready !== 1'b1) begin n_fail++; $display("FAIL brake_ready got=%b exp=1", auto_ready); end
    auto_valid = 1'b1; auto_cmd = 4'b0001; tick();
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL brake_prio got=%b exp=00", state); end
    man_next_state = 2'b01; tick();
    auto_cmd = 4'b1000; tick();
    n_checks++; if (state !== 2'b10 || moving_state !== 4'b0001 || auto_ready !== 1'b1) begin n_fail++; $display("FAIL junk_cmd got=%b/%b/%b exp=10/0001/1", state, moving_state, auto_ready); end
    auto_cmd = 4'b0000; tick();
    n_checks++; if (state !== 2'b01 || moving_state !== 4'b0000) begin n_fail++; $display("FAIL non_moving got=%b/%b exp=01/0000", state, moving_state); end
    auto_valid = 1'b0;
  endtask

  task automatic test_idle();
    rst = 1'b1; tick(); rst = 1'b0;
    mode_sel = 2'b00; man_next_state = 2'b00; man_next_moving = 4'b0000; man_power = 1'b1;
    power_on();
`ifdef IDLE_OFF_EN
    repeat (IDLE - 1) tick();
    n_checks++; if (power !== 1'b1) begin n_fail++; $display("FAIL idle_early got=%b exp=1", power); end
    tick();
    n_checks++; if (power !== 1'b0) begin n_fail++; $display("FAIL idle_off got=%b exp=0", power); end
`else
    repeat (3 * IDLE) tick();
    n_checks++; if (power !== 1'b1) begin n_fail++; $display("FAIL idle_stays_on got=%b exp=1", power); end
`endif
  endtask

  task automatic test_random();
    logic [3:0] cmds [6];
    cmds = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0011};
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) power_btn = ~power_btn;
      man_power = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) mode_sel = 2'($urandom_range(0, 3));
      man_next_state = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
      man_next_moving = 4'(1 << $urandom_range(0, 3));
      auto_valid = ($urandom_range(0, 2) == 0);
      auto_cmd = cmds[$urandom_range(0, 5)];
      rst = ($urandom_range(0, 999) == 0);
      tick();
      n_checks++; if (power !== m_power) begin n_fail++; $display("FAIL rnd_power cyc=%0d got=%b exp=%b", i, power, m_power); end
      n_checks++; if (state !== m_state) begin n_fail++; $display("FAIL rnd_state cyc=%0d got=%b exp=%b", i, state, m_state); end
      n_checks++; if (moving_state !== m_moving) begin n_fail++; $display("FAIL rnd_moving cyc=%0d got=%b exp=%b", i, moving_state, m_moving); end
      n_checks++; if (active_mode !== m_active) begin n_fail++; $display("FAIL rnd_active cyc=%0d got=%b exp=%b", i, active_mode, m_active); end
      n_checks++; if (auto_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, auto_ready, m_ready); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; power_btn = 1'b0; mode_sel = 2'b00;
    man_next_state = 2'b00; man_next_moving = 4'b0000; man_power = 1'b1;
    auto_valid = 1'b0; auto_cmd = 4'b0000;
    m_power = 0; m_active = 0; m_ready = 0; m_lock = 0;
    m_state = 2'b00; m_moving = 4'b0000; m_hold = 0; m_turn = 0; m_idle = 0;
    test_reset();
    test_power_toggle();
    test_manual();
    test_mode_switch();
    test_auto_turn();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
